// File: rtl/led_driver.sv
// Purpose : write-only LED control registers feeding a tick-driven PWM engine with blink envelope.
// Latency : register write -> led on the second rising edge; pwm/blink state -> led after one register stage.
// Backpr. : none; writes accepted every cycle, counters advance only on tick, led holds when tick is low.
//
// Ports:
//   clock            single clock, rising edge
//   n_reset          asynchronous active-low reset
//   tick             one-cycle advance enable (may be held high)
//   wr_en            register write strobe, sampled every cycle
//   wr_addr[1:0]     0=CTRL {invert,blink_en,enable}, 1=DUTY, 2=BLINK_HALF, 3=ignored
//   wr_data[31:0]    write data, bits above each field width are dropped
//   led              registered LED drive
module led_driver #(
  parameter int PWM_BITS   = 8,
  parameter int BLINK_BITS = 16
) (
  input  logic        clock,
  input  logic        n_reset,
  input  logic        tick,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        led
);

  typedef enum logic {
    ON_PHASE  = 1'b0,
    OFF_PHASE = 1'b1
  } blink_state_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLINK = 1;
  localparam int CTRL_INV   = 2;

  // Register file
  logic [2:0]            ctrl_q, ctrl_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [BLINK_BITS-1:0] blink_half_q, blink_half_d;

  // PWM engine
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]   duty_active_q, duty_active_d;

  // Blink FSM
  blink_state_e          state_q, state_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;

  // Output stage
  logic                  led_q, led_d;

  // Decode / control
  logic                  wr_ctrl, wr_duty, wr_blink;
  logic                  run;
  logic                  frame_end;
  logic                  blink_hold;
  logic [BLINK_BITS-1:0] blink_last;
  logic                  pwm_on;

  // Only the low bits of wr_data feed any field.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;

  // ---------------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ctrl  = wr_en && (wr_addr == 2'd0);
    wr_duty  = wr_en && (wr_addr == 2'd1);
    wr_blink = wr_en && (wr_addr == 2'd2);

    ctrl_d       = wr_ctrl  ? wr_data[2:0]            : ctrl_q;
    duty_d       = wr_duty  ? wr_data[PWM_BITS-1:0]   : duty_q;
    blink_half_d = wr_blink ? wr_data[BLINK_BITS-1:0] : blink_half_q;
  end

  // ---------------------------------------------------------------------------
  // PWM engine
  // ---------------------------------------------------------------------------
  // The engine runs only when enable is set both before and after this edge:
  // a CTRL write that clears enable wins over a coincident frame_end and
  // clears the counters on that same edge, while a 0->1 write leaves the
  // counters at 0 so the first enabled frame starts cleanly at pwm_cnt=0.
  always_comb begin
    run       = ctrl_q[CTRL_EN] & ctrl_d[CTRL_EN];
    frame_end = run & tick & (pwm_cnt_q == {PWM_BITS{1'b1}});

    pwm_cnt_d     = pwm_cnt_q;
    duty_active_d = duty_active_q;

    if (!run) begin
      // Disabled: track DUTY continuously (including a write landing this
      // edge) so enabling starts with the current value.
      pwm_cnt_d     = '0;
      duty_active_d = duty_d;
    end else if (tick) begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      // Shadow load at the frame boundary only; duty_d lets a coincident
      // DUTY write take effect for the next frame.
      if (frame_end) begin
        duty_active_d = duty_d;
      end
    end
  end

  assign pwm_on = (pwm_cnt_q < duty_active_q);

  // ---------------------------------------------------------------------------
  // Blink FSM: next state
  // ---------------------------------------------------------------------------
  // A half period of 0 behaves like 1 frame.
  assign blink_last = (blink_half_q == '0) ? '0 : (blink_half_q - BLINK_BITS'(1));

  always_comb begin
    blink_hold = !run
               || !(ctrl_q[CTRL_BLINK] && ctrl_d[CTRL_BLINK])
               || wr_blink;

    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;

    if (blink_hold) begin
      state_d     = ON_PHASE;
      blink_cnt_d = '0;
    end else if (frame_end) begin
      // >= rather than == keeps the counter bounded whatever its history.
      if (blink_cnt_q >= blink_last) begin
        blink_cnt_d = '0;
        state_d     = (state_q == ON_PHASE) ? OFF_PHASE : ON_PHASE;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output
  // ---------------------------------------------------------------------------
  // Built from registered state only, so every register write reaches the
  // pin exactly one edge after it lands.
  always_comb begin
    led_d = (ctrl_q[CTRL_EN] & pwm_on
             & (~ctrl_q[CTRL_BLINK] | (state_q == ON_PHASE)))
            ^ ctrl_q[CTRL_INV];
  end

  assign led = led_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ctrl_q        <= '0;
      duty_q        <= '0;
      blink_half_q  <= '0;
      pwm_cnt_q     <= '0;
      duty_active_q <= '0;
      blink_cnt_q   <= '0;
      state_q       <= ON_PHASE;
      led_q         <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      duty_q        <= duty_d;
      blink_half_q  <= blink_half_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_active_q <= duty_active_d;
      blink_cnt_q   <= blink_cnt_d;
      state_q       <= state_d;
      led_q         <= led_d;
    end
  end

endmodule

// File: tb/tb_led_driver.sv
module tb_led_driver;

  logic        clock;
  logic        n_reset;
  logic        tick;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        led;

  led_driver #(.PWM_BITS(8), .BLINK_BITS(16)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .tick    (tick),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .led     (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int hi_acc   = 0;
  int gi       = 0;

  // Reference model: register contents plus position in the frame and
  // number of frames completed since the blink envelope last restarted.
  int unsigned m_en, m_ben, m_inv;
  int unsigned m_duty, m_bh, m_dact;
  int unsigned m_pos, m_frames;

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, got, want);
  endtask

  task automatic model_reset();
    m_en = 0; m_ben = 0; m_inv = 0;
    m_duty = 0; m_bh = 0; m_dact = 0;
    m_pos = 0; m_frames = 0;
  endtask

  function automatic int model_led();
    int unsigned h;
    bit on, lit;
    h   = (m_bh == 0) ? 1 : m_bh;
    on  = ((m_frames / h) % 2) == 0;
    lit = (m_en != 0) && (m_pos < m_dact) && ((m_ben == 0) || on);
    return int'(lit ^ (m_inv != 0));
  endfunction

  task automatic model_step(input bit t, input bit we, input bit [1:0] a, input bit [31:0] d);
    int unsigned n_en, n_ben, n_inv, n_duty, n_bh, h;
    bit run, fe;
    n_en = m_en; n_ben = m_ben; n_inv = m_inv; n_duty = m_duty; n_bh = m_bh;
    if (we && a == 2'd0) begin n_en = d[0]; n_ben = d[1]; n_inv = d[2]; end
    if (we && a == 2'd1) n_duty = d & 32'hFF;
    if (we && a == 2'd2) n_bh = d & 32'hFFFF;
    run = (m_en != 0) && (n_en != 0);
    fe  = run && t && (m_pos == 255);
    h   = (m_bh == 0) ? 1 : m_bh;
    if (!run || m_ben == 0 || n_ben == 0 || (we && a == 2'd2)) m_frames = 0;
    else if (fe) m_frames = (m_frames + 1) % (2 * h);
    if (!run) begin
      m_pos  = 0;
      m_dact = n_duty;
    end else if (t) begin
      if (fe) m_dact = n_duty;
      m_pos = (m_pos + 1) % 256;
    end
    m_en = n_en; m_ben = n_ben; m_inv = n_inv; m_duty = n_duty; m_bh = n_bh;
  endtask

  // One clock cycle: drive inputs, advance model, check led after the edge.
  task automatic cyc(input bit t, input bit we, input bit [1:0] a, input bit [31:0] d);
    int exp;
    tick = t; wr_en = we; wr_addr = a; wr_data = d;
    if (n_reset) begin
      exp = model_led();
      model_step(t, we, a, d);
    end else begin
      exp = 0;
      model_reset();
    end
    @(posedge clock);
    #1;
    check("led_cycle", int'(led), exp);
    if (led) hi_acc++;
    @(negedge clock);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'd0, $urandom);
  endtask

  // Tick every 4th cycle, pattern continuing across calls.
  task automatic run_slow(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(gi % 4 == 0, 1'b0, 2'd0, 32'h0);
      gi++;
    end
  endtask

  int base;

  initial begin
    n_reset = 1'b0; tick = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 32'h0;
    model_reset();
    @(negedge clock);

    // Reset state, then 1000 idle cycles with no writes.
    cyc(1'b1, 1'b0, 2'd0, 32'h0);
    cyc(1'b1, 1'b0, 2'd0, 32'h0);
    check("reset_led", int'(led), 0);
    n_reset = 1'b1;
    base = hi_acc; run_idle(1000);
    check("idle_after_reset_high", hi_acc - base, 0);

    // Basic PWM at duty 64.
    cyc(1'b1, 1'b1, 2'd1, 32'hABCD_FF40);   // upper bits ignored -> 64
    cyc(1'b1, 1'b1, 2'd0, 32'h1);
    base = hi_acc; run_idle(256);
    check("pwm64_frame0", hi_acc - base, 64);
    base = hi_acc; run_idle(256);
    check("pwm64_frame1", hi_acc - base, 64);

    // Mid-frame rewrite to 128: current frame keeps 64.
    base = hi_acc; run_idle(100);
    cyc(1'b1, 1'b1, 2'd1, 32'd128);
    run_idle(155);
    check("shadow_old_frame", hi_acc - base, 64);
    base = hi_acc; run_idle(256);
    check("shadow_new_frame", hi_acc - base, 128);

    // DUTY write exactly on the frame_end cycle.
    base = hi_acc; run_idle(255);
    cyc(1'b1, 1'b1, 2'd1, 32'd10);
    check("coincident_cur_frame", hi_acc - base, 128);
    base = hi_acc; run_idle(256);
    check("coincident_next_frame", hi_acc - base, 10);

    // Duty 0 and 255.
    cyc(1'b1, 1'b1, 2'd1, 32'd0); run_idle(255);
    base = hi_acc; run_idle(256);
    check("duty0_frame", hi_acc - base, 0);
    cyc(1'b1, 1'b1, 2'd1, 32'd255); run_idle(255);
    base = hi_acc; run_idle(256);
    check("duty255_frame", hi_acc - base, 255);

    // Blink: half period of 2 frames -> 1024-cycle period, 510 high.
    cyc(1'b1, 1'b1, 2'd2, 32'd2);
    cyc(1'b1, 1'b1, 2'd0, 32'd3);
    run_idle(1024);
    base = hi_acc; run_idle(1024);
    check("blink_period_high", hi_acc - base, 510);
    base = hi_acc; run_idle(1024);
    check("blink_period_high2", hi_acc - base, 510);

    // Disabled with invert: constant 1.
    cyc(1'b1, 1'b1, 2'd0, 32'd4);
    run_idle(4);
    base = hi_acc; run_idle(300);
    check("invert_disabled_high", hi_acc - base, 300);

    // Tick every 4th cycle stretches the frame to 1024 cycles.
    cyc(1'b0, 1'b1, 2'd1, 32'd64);
    cyc(1'b0, 1'b1, 2'd0, 32'd1);
    gi = 0;
    base = hi_acc; run_slow(1024);
    check("slow_tick_frame", hi_acc - base, 256);

    // Address 3 write changes nothing.
    base = hi_acc;
    cyc(gi % 4 == 0, 1'b1, 2'd3, 32'hFFFF_FFFF); gi++;
    run_slow(1023);
    check("addr3_no_effect", hi_acc - base, 256);

    // Asynchronous reset while led is high.
    cyc(1'b1, 1'b1, 2'd1, 32'd200);
    for (int i = 0; i < 600 && !led; i++) cyc(1'b1, 1'b0, 2'd0, 32'h0);
    check("led_high_before_reset", int'(led), 1);
    #2 n_reset = 1'b0;
    #1 check("async_reset_led", int'(led), 0);
    model_reset();
    @(negedge clock);
    cyc(1'b1, 1'b0, 2'd0, 32'h0);
    n_reset = 1'b1;
    base = hi_acc; run_idle(300);
    check("post_reset_idle", hi_acc - base, 0);

    // Randomized traffic against the model.
    cyc(1'b1, 1'b1, 2'd1, $urandom);
    cyc(1'b1, 1'b1, 2'd0, 32'd1);
    for (int i = 0; i < 20000; i++) begin
      bit t;
      bit [1:0] a;
      bit [31:0] d;
      t = ($urandom % 4) != 0;
      if ($urandom % 300 == 0) begin
        a = 2'($urandom % 4);
        d = $urandom;
        if (a == 2'd0 && ($urandom % 4) != 0) d[0] = 1'b1;
        if (a == 2'd2) d = (d & 32'hFFFF_0000) | ($urandom % 4);
        cyc(t, 1'b1, a, d);
      end else begin
        cyc(t, 1'b0, 2'($urandom % 4), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
